// File: rtl/mult_div_unit_if.sv
// Operand/control/result bundle between the execute stage and the multiply/divide unit.
// master: drives A, B, op, start, hi_we, lo_we, wdata; observes busy, done, hi, lo.
// slave : the multiply/divide unit itself (opposite directions).
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       op;
  logic             start;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output A, B, op, start, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  A, B, op, start, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Ports: clk, rst_n (async active-low); bus (slave): A/B operands, op, start, MTHI/MTLO
// strobes + wdata in; busy, done pulse, hi, lo out. Latency 33 cycles start->done, no queueing.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mult_div_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state;
  state_t      state_nxt;

  logic        is_div;    // latched op[1]
  logic        neg_q;     // negate product (mul) or quotient (div)
  logic        neg_r;     // negate remainder (signed divide, negative dividend)
  logic        div0;      // divisor was zero
  logic [31:0] a_raw;     // original dividend, returned in HI on divide by zero
  logic [31:0] a_mag;     // multiplicand, or dividend bits still to shift in
  logic [31:0] b_mag;     // multiplier (shifts right), or divisor
  logic [63:0] acc;       // product, or {remainder, quotient}
  logic [4:0]  cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  logic        accept;
  logic        signed_op;
  logic [31:0] a_abs;
  logic [31:0] b_abs;

  logic [32:0] mul_sum;
  logic [63:0] mul_nxt;
  logic [32:0] div_rem;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [63:0] div_nxt;

  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic [31:0] hi_res;
  logic [31:0] lo_res;

  assign accept    = (state == IDLE) && bus.start;
  assign signed_op = ~bus.op[0];
  // Magnitudes are kept as 32-bit unsigned, so |0x80000000| = 0x80000000 fits.
  assign a_abs = (signed_op && bus.A[31]) ? (~bus.A + 32'd1) : bus.A;
  assign b_abs = (signed_op && bus.B[31]) ? (~bus.B + 32'd1) : bus.B;

  // Shift-add: add multiplicand into the upper 33 bits, then shift right.
  assign mul_sum = {1'b0, acc[63:32]} + (b_mag[0] ? {1'b0, a_mag} : 33'd0);
  assign mul_nxt = {mul_sum, acc[31:1]};

  // Restoring divide: the next dividend bit enters the remainder from a_mag;
  // the remainder needs 33 bits for one cycle before the compare.
  assign div_rem  = {acc[63:32], a_mag[31]};
  assign div_diff = div_rem - {1'b0, b_mag};
  assign div_ge   = (div_rem >= {1'b0, b_mag});
  assign div_nxt  = {(div_ge ? div_diff[31:0] : div_rem[31:0]), acc[30:0], div_ge};

  assign prod_fix = neg_q ? (~acc + 64'd1) : acc;
  assign quot_fix = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
  assign rem_fix  = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];

  always_comb begin
    hi_res = prod_fix[63:32];
    lo_res = prod_fix[31:0];
    if (is_div) begin
      if (div0) begin
        hi_res = a_raw;
        lo_res = 32'hFFFF_FFFF;
      end else begin
        hi_res = rem_fix;
        lo_res = quot_fix;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Iteration datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      a_raw  <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept) begin
      is_div <= bus.op[1];
      neg_q  <= signed_op & (bus.A[31] ^ bus.B[31]);
      neg_r  <= signed_op & bus.op[1] & bus.A[31];
      div0   <= (bus.B == 32'd0);
      a_raw  <= bus.A;
      a_mag  <= a_abs;
      b_mag  <= b_abs;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == CALC) begin
      cnt <= cnt + 5'd1;
      if (is_div) begin
        acc   <= div_nxt;
        a_mag <= {a_mag[30:0], 1'b0};
      end else begin
        acc   <= mul_nxt;
        b_mag <= {1'b0, b_mag[31:1]};
      end
    end
  end

  // HI/LO: FIX result, or MTHI/MTLO only in IDLE when no start is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == FIX);
      if (state == FIX) begin
        hi_q <= hi_res;
        lo_q <= lo_res;
      end else if (state == IDLE && !bus.start) begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  mult_div_unit_if #(.WIDTH(32)) bus();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;    // cycle count at the accepting edge
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi", {32'd0, bus.hi}, {32'd0, e.hi});
        check("lo", {32'd0, bus.lo}, {32'd0, e.lo});
        check("latency", 64'(cyc - e.n), 64'd33);
      end
    end
  end

  // Called at a negedge; returns just after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                       input bit push, input logic [31:0] eh, input logic [31:0] el);
    bus.A     = a;
    bus.B     = b;
    bus.op    = o;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = 32'h5A5A_5A5A;
    bus.B     = 32'hA5A5_A5A5;
    if (push) sb.push_back('{eh, el, cyc});
  endtask

  // Counts busy cycles after issue; bounded.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
  endtask

  task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] o, input logic [31:0] eh, input logic [31:0] el);
    int n;
    issue(a, b, o, 1'b1, eh, el);
    wait_idle(n);
    check(name, 64'(n), 64'd33);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit seen;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.op    = 2'b00;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_hi", {32'd0, bus.hi}, 64'd0);
    check("rst_lo", {32'd0, bus.lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Arithmetic vectors (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
    run("busy_multu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'hFFFF_FFFE, 32'h0000_0001);
    run("busy_mult_neg",  32'hFFFF_FFFD, 32'd5,         2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run("busy_div_neg",   32'hFFFF_FFF9, 32'd2,         2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("busy_divu",      32'd17,        32'd13,        2'b11, 32'd4,         32'd1);
    run("busy_div_ovf",   32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'd0,         32'h8000_0000);
    run("busy_divu_0",    32'h1234_5678, 32'd0,         2'b11, 32'h1234_5678, 32'hFFFF_FFFF);
    run("busy_div_0",     32'hFFFF_FFF0, 32'd0,         2'b10, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

    // DIVU 100/7 with an ignored MULTU start and an ignored MTHI while busy
    issue(32'd100, 32'd7, 2'b11, 1'b1, 32'd2, 32'd14);
    repeat (4) @(negedge clk);
    issue(32'd3, 32'd4, 2'b01, 1'b0, 32'd0, 32'd0);
    check("busy_after_ignored_start", {63'd0, bus.busy}, 64'd1);
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    check("hi_we_while_busy", {32'd0, bus.hi}, {32'd0, 32'hFFFF_FFF0});
    wait_idle(n);

    // MTLO in IDLE, then MTHI+MTLO together
    bus.lo_we = 1'b1;
    bus.wdata = 32'hCAFE_BABE;
    @(posedge clk);
    #1;
    bus.lo_we = 1'b0;
    check("mtlo_lo", {32'd0, bus.lo}, {32'd0, 32'hCAFE_BABE});
    check("mtlo_hi_kept", {32'd0, bus.hi}, 64'd2);
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("mthi_both", {32'd0, bus.hi}, {32'd0, 32'h0BAD_F00D});
    check("mtlo_both", {32'd0, bus.lo}, {32'd0, 32'h0BAD_F00D});

    // start wins over a simultaneous MTLO
    @(negedge clk);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h1111_2222;
    issue(32'd9, 32'd3, 2'b11, 1'b1, 32'd0, 32'd3);
    bus.lo_we = 1'b0;
    check("start_beats_mtlo", {32'd0, bus.lo}, {32'd0, 32'h0BAD_F00D});
    wait_idle(n);
    check("busy_start_mtlo", 64'(n), 64'd33);

    // Back-to-back: new start in the done cycle
    @(negedge clk);
    issue(32'hFFFF_FFFF, 32'h8000_0000, 2'b00, 1'b1, 32'd0, 32'h8000_0000);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("b2b_done_seen", {63'd0, seen}, 64'd1);
    issue(32'h0001_0000, 32'h0001_0000, 2'b01, 1'b1, 32'd1, 32'd0);
    check("b2b_accepted", {63'd0, bus.busy}, 64'd1);
    wait_idle(n);
    check("busy_b2b", 64'(n), 64'd33);

    // Reset mid-MULT: everything clears at once, no done follows
    @(negedge clk);
    issue(32'd7, 32'd9, 2'b00, 1'b1, 32'd0, 32'd63);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {63'd0, bus.busy}, 64'd0);
    check("arst_done", {63'd0, bus.done}, 64'd0);
    check("arst_hi", {32'd0, bus.hi}, 64'd0);
    check("arst_lo", {32'd0, bus.lo}, 64'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    run("busy_after_rst", 32'd6, 32'd7, 2'b01, 32'd0, 32'd42);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
